atta_irq_ctrl: RTL and testbench
================================

ATTA_IRQ_CTRL -- requirements
Module: atta_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources, legal range 1..32.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0300_0000, register block base address, 16-byte aligned.
REQ-003 SHALL have port clk_i  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port src_i  input  NUM_SRC  interrupt source lines.
REQ-006 SHALL have port mem_valid_i  input  1  CPU bus request valid.
REQ-007 SHALL have port mem_addr_i  input  32  CPU byte address.
REQ-008 SHALL have port mem_wdata_i  input  32  write data.
REQ-009 SHALL have port mem_wstrb_i  input  4  byte write strobes; all-zero means read.
REQ-010 SHALL have port mem_ready_o  output  1  access-complete strobe.
REQ-011 SHALL have port mem_rdata_o  output  32  read data, valid while mem_ready_o=1.
REQ-012 SHALL have port irq_o  output  32  CPU IRQ vector, bits NUM_SRC..31 tied 0.

Function
REQ-013 SHALL select the block when mem_addr_i[31:4]==BASE_ADDR[31:4], using offset mem_addr_i[3:2]; unselected accesses get no response.
REQ-014 SHALL implement registers: 0x0 PENDING (R, write-1-to-clear), 0x4 ENABLE (RW), 0x8 EDGE (RW, 1=rising-edge, 0=level), 0xC ACTIVE (RO).
REQ-015 ACTIVE SHALL read {valid, 26'b0, id[4:0]}, where id is the lowest index with PENDING&ENABLE set and valid is bit 31; it SHALL read 0 when none.
REQ-016 Register bits at index >=NUM_SRC SHALL read 0 and ignore writes; writes to ACTIVE SHALL be ignored but acknowledged.
REQ-017 Writes SHALL update only the byte lanes whose mem_wstrb_i bit is 1.
REQ-018 The bus FSM SHALL have states IDLE, ACK, WAIT: IDLE->ACK when mem_valid_i and selected (access performed on that edge); ACK->WAIT unconditionally; WAIT->IDLE when mem_valid_i=0.
REQ-019 mem_ready_o SHALL be registered and high exactly one cycle (state ACK); mem_rdata_o SHALL hold the value sampled at the IDLE->ACK edge and be 0 outside ACK.
REQ-020 Sources SHALL be sampled into flop s; edge detect SHALL compare s with its previous value sp.
REQ-021 Edge mode: PENDING[i] SHALL set on s[i]&~sp[i] and clear only by W1C; a set and a W1C on the same bit in the same cycle SHALL leave it set.
REQ-022 Level mode: PENDING[i] SHALL equal s[i] registered each cycle; W1C SHALL have no effect.
REQ-023 A write to EDGE SHALL clear PENDING bits whose EDGE value changes.
REQ-024 irq_o SHALL be PENDING & ENABLE (combinational from registers), so a source rising before edge k asserts irq_o after edge k+1.
REQ-025 Disabling via ENABLE SHALL mask irq_o but not clear PENDING.

Reset
REQ-026 rst_i high at an edge SHALL clear PENDING, ENABLE, EDGE, s, sp and synchronizer flops, force FSM to IDLE, and drive mem_ready_o=0, mem_rdata_o=0, irq_o=0 from the next cycle.
REQ-027 Reset during ACK or WAIT SHALL abandon the access with no further mem_ready_o pulse.

Configuration
REQ-028 Macro ATTA_IRQ_SYNC_EN defined: src_i SHALL pass through a two-flop synchronizer before s, adding 2 cycles (irq_o after edge k+3).
REQ-029 Macro ATTA_IRQ_SYNC_EN undefined: src_i SHALL feed s directly (irq_o after edge k+1).

Verification
REQ-030 Reset, read 0x0/0x4/0x8/0xC -> all return 32'h0; irq_o=0; each mem_ready_o one cycle.
REQ-031 Write ENABLE=0xFF, EDGE=0x01, pulse src_i[0] 1 cycle -> PENDING=0x01, irq_o=0x01, ACTIVE=0x8000_0000; W1C 0x01 -> irq_o=0.
REQ-032 EDGE=0, ENABLE=0x08, hold src_i[3]=1 -> irq_o=0x08, W1C 0x08 leaves it set; drop src_i[3] -> irq_o=0 two cycles later.
REQ-033 Edge mode, src_i[2] and src_i[5] rise together with ENABLE=0x24 -> ACTIVE=0x8000_0002; W1C 0x04 -> ACTIVE=0x8000_0005.
REQ-034 W1C of bit 1 in the same cycle a rising edge on bit 1 sets it -> PENDING[1] remains 1.
REQ-035 Byte write wstrb=4'b0010 data 0xFFFF_FFFF to ENABLE with NUM_SRC=16 -> ENABLE=0x0000_FF00; rst_i asserted in ACK -> no further ready, all regs 0.

Source files
------------

// File: rtl/atta_irq_ctrl.sv
//==============================================================================
// Module      : atta_irq_ctrl
// Description : Memory-mapped interrupt controller with pending, enable, edge
//               and active registers and a single-beat CPU bus handshake.
//               Optional macro ATTA_IRQ_SYNC_EN adds a two-flop input
//               synchronizer ahead of the source sample flop.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module atta_irq_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               mem_valid_i,
    input  logic [31:0]        mem_addr_i,
    input  logic [31:0]        mem_wdata_i,
    input  logic [3:0]         mem_wstrb_i,
    output logic               mem_ready_o,
    output logic [31:0]        mem_rdata_o,
    output logic [31:0]        irq_o
);

    localparam logic [1:0] c_OFF_PENDING = 2'd0;
    localparam logic [1:0] c_OFF_ENABLE  = 2'd1;
    localparam logic [1:0] c_OFF_EDGE    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_mode_q, edge_mode_d;
    logic [NUM_SRC-1:0] s_q, s_d;
    logic [NUM_SRC-1:0] sp_q;

    logic               w_sel;
    logic               w_access;
    logic               w_write;
    logic [1:0]         w_off;
    logic [NUM_SRC-1:0] w_wmask;
    logic [NUM_SRC-1:0] w_wdata;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_mode_chg;
    logic [NUM_SRC-1:0] w_act_bits;
    logic               w_act_valid;
    logic [4:0]         w_act_id;
    logic [31:0]        w_pend32, w_en32, w_edge32;
    logic [31:0]        w_rd;
    logic               w_unused;

    assign w_sel    = (mem_addr_i[31:4] == BASE_ADDR[31:4]);
    assign w_off    = mem_addr_i[3:2];
    assign w_access = (state_q == ST_IDLE) && mem_valid_i && w_sel;
    assign w_write  = w_access && (mem_wstrb_i != 4'b0000);
    assign w_wdata  = mem_wdata_i[NUM_SRC-1:0];
    assign w_unused = ^{mem_addr_i[1:0], mem_wdata_i, mem_wstrb_i};

    // Each register bit follows the strobe of the byte lane it lives in.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_wmask
        assign w_wmask[gi] = mem_wstrb_i[gi/8];
    end

`ifdef ATTA_IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end

    assign s_d = sync2_q;
`else
    assign s_d = src_i;
`endif

    always_comb begin
        w_pend32                 = '0;
        w_en32                   = '0;
        w_edge32                 = '0;
        w_pend32[NUM_SRC-1:0]    = pending_q;
        w_en32[NUM_SRC-1:0]      = enable_q;
        w_edge32[NUM_SRC-1:0]    = edge_mode_q;
    end

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    assign w_act_bits = pending_q & enable_q;
    always_comb begin
        w_act_valid = 1'b0;
        w_act_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_act_bits[i]) begin
                w_act_valid = 1'b1;
                w_act_id    = 5'(i);
            end
        end
    end

    always_comb begin
        case (w_off)
            c_OFF_PENDING: w_rd = w_pend32;
            c_OFF_ENABLE:  w_rd = w_en32;
            c_OFF_EDGE:    w_rd = w_edge32;
            default:       w_rd = {w_act_valid, 26'b0, w_act_id};
        endcase
    end

    always_comb begin
        enable_d    = enable_q;
        edge_mode_d = edge_mode_q;
        w_w1c       = '0;
        if (w_write) begin
            case (w_off)
                c_OFF_PENDING: w_w1c       = w_wdata & w_wmask;
                c_OFF_ENABLE:  enable_d    = (enable_q & ~w_wmask) | (w_wdata & w_wmask);
                c_OFF_EDGE:    edge_mode_d = (edge_mode_q & ~w_wmask) | (w_wdata & w_wmask);
                default:       w_w1c       = '0;
            endcase
        end
    end

    assign w_rise     = s_q & ~sp_q;
    assign w_mode_chg = edge_mode_d ^ edge_mode_q;

    // A fresh edge beats a simultaneous W1C; a mode change discards history.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_mode_q[i]) begin
                pending_d[i] = (pending_q[i] & ~w_w1c[i]) | w_rise[i];
            end else begin
                pending_d[i] = s_q[i];
            end
        end
        pending_d = pending_d & ~w_mode_chg;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_access)     state_d = ST_ACK;
            ST_ACK:                    state_d = ST_WAIT;
            ST_WAIT: if (!mem_valid_i) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    assign ready_d = w_access;
    assign rdata_d = w_access ? w_rd : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            s_q         <= '0;
            sp_q        <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            s_q         <= s_d;
            sp_q        <= s_q;
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign irq_o       = w_pend32 & w_en32;

endmodule

`default_nettype wire

// File: tb/tb_atta_irq_ctrl.sv
//==============================================================================
// Module      : tb_atta_irq_ctrl
// Description : Self-checking bench for atta_irq_ctrl (NUM_SRC=16), honours
//               ATTA_IRQ_SYNC_EN for source latency.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_atta_irq_ctrl;

    localparam int          N     = 16;
    localparam logic [31:0] BASE  = 32'h0300_0000;
    localparam logic [31:0] NMASK = 32'h0000_FFFF;
`ifdef ATTA_IRQ_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam logic [31:0] A_PEND = BASE + 32'h0;
    localparam logic [31:0] A_EN   = BASE + 32'h4;
    localparam logic [31:0] A_EDGE = BASE + 32'h8;
    localparam logic [31:0] A_ACT  = BASE + 32'hC;

    logic          clk;
    logic          rst_i;
    logic [N-1:0]  src_i;
    logic          mem_valid_i;
    logic [31:0]   mem_addr_i;
    logic [31:0]   mem_wdata_i;
    logic [3:0]    mem_wstrb_i;
    logic          mem_ready_o;
    logic [31:0]   mem_rdata_o;
    logic [31:0]   irq_o;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    atta_irq_ctrl #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .src_i       (src_i),
        .mem_valid_i (mem_valid_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_ready_o (mem_ready_o),
        .mem_rdata_o (mem_rdata_o),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_pend = '0, m_en = '0, m_edge = '0, exp_rdata = '0;
    logic        exp_ready = 1'b0;
    int          phase = 0;
    logic [31:0] hist [0:3] = '{default: 32'h0};

    function automatic logic [31:0] bytemask(input logic [3:0] st);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{st[b]}};
        return m;
    endfunction

    function automatic logic [31:0] active_of(input logic [31:0] p, input logic [31:0] e);
        for (int i = 0; i < 32; i++)
            if (p[i] && e[i]) return 32'h8000_0000 | 32'(i);
        return 32'h0;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] s, sp, rv, bm, w1c, new_en, new_edge, chg, np;
        logic        acc, wr;
        logic [1:0]  off;
        if (rst_i) begin
            m_pend = '0; m_en = '0; m_edge = '0;
            phase = 0; exp_ready = 1'b0; exp_rdata = '0;
            for (int j = 0; j < 4; j++) hist[j] = '0;
        end else begin
            s   = hist[D];
            sp  = hist[D+1];
            acc = (phase == 0) && mem_valid_i && (mem_addr_i[31:4] == BASE[31:4]);
            wr  = acc && (mem_wstrb_i != 4'b0);
            off = mem_addr_i[3:2];
            bm  = bytemask(mem_wstrb_i);
            case (off)
                2'd0:    rv = m_pend;
                2'd1:    rv = m_en;
                2'd2:    rv = m_edge;
                default: rv = active_of(m_pend, m_en);
            endcase
            new_en = m_en; new_edge = m_edge; w1c = '0;
            if (wr) begin
                case (off)
                    2'd0: w1c      = mem_wdata_i & bm & NMASK;
                    2'd1: new_en   = ((m_en & ~bm) | (mem_wdata_i & bm)) & NMASK;
                    2'd2: new_edge = ((m_edge & ~bm) | (mem_wdata_i & bm)) & NMASK;
                    default: ;
                endcase
            end
            chg = new_edge ^ m_edge;
            np  = '0;
            for (int i = 0; i < N; i++) begin
                if (chg[i])         np[i] = 1'b0;
                else if (m_edge[i]) np[i] = (m_pend[i] & ~w1c[i]) | (s[i] & ~sp[i]);
                else                np[i] = s[i];
            end
            m_pend = np; m_en = new_en; m_edge = new_edge;
            exp_ready = acc;
            exp_rdata = acc ? rv : 32'h0;
            case (phase)
                0: if (acc) phase = 1;
                1: phase = 2;
                default: if (!mem_valid_i) phase = 0;
            endcase
            for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = 32'(src_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (irq_o !== (m_pend & m_en & NMASK)) begin
                fails++;
                $display("FAIL model_irq @%0t: got %h expected %h", $time, irq_o, m_pend & m_en & NMASK);
            end
            tests++;
            if (mem_ready_o !== exp_ready) begin
                fails++;
                $display("FAIL model_ready @%0t: got %b expected %b", $time, mem_ready_o, exp_ready);
            end
            tests++;
            if (mem_rdata_o !== exp_rdata) begin
                fails++;
                $display("FAIL model_rdata @%0t: got %h expected %h", $time, mem_rdata_o, exp_rdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_go(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rd);
        bit got;
        mem_valid_i = 1'b1; mem_addr_i = addr; mem_wdata_i = wdata; mem_wstrb_i = strb;
        got = 1'b0;
        rd  = '0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (mem_ready_o) begin
                got = 1'b1;
                rd  = mem_rdata_o;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL bus_timeout: got no ready expected ready for addr %h", addr);
        end
        @(posedge clk); #2;
        mem_valid_i = 1'b0; mem_wstrb_i = 4'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] dummy;
        @(posedge clk); #2;
        bus_go(addr, data, strb, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        @(posedge clk); #2;
        bus_go(addr, 32'h0, 4'b0, data);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] v;
        int          cnt;
        rst_i = 1'b1; src_i = '0; mem_valid_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; mem_wstrb_i = '0;
        @(posedge clk); #2 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_i = 1'b0;

        // reset state
        rd(A_PEND, v); chk("rst_pending", v, 32'h0);
        rd(A_EN,   v); chk("rst_enable",  v, 32'h0);
        rd(A_EDGE, v); chk("rst_edge",    v, 32'h0);
        rd(A_ACT,  v); chk("rst_active",  v, 32'h0);
        chk("rst_irq", irq_o, 32'h0);

        // unselected address gets no response
        @(posedge clk); #2;
        mem_valid_i = 1'b1; mem_addr_i = BASE + 32'h10; mem_wstrb_i = 4'b0;
        cnt = 0;
        repeat (5) begin @(negedge clk); if (mem_ready_o) cnt++; end
        chk("unselected_no_ready", 32'(cnt), 32'h0);
        @(posedge clk); #2 mem_valid_i = 1'b0;
        @(posedge clk);

        // edge pulse on source 0
        wr(A_EN, 32'hFF, 4'hF);
        wr(A_EDGE, 32'h01, 4'hF);
        @(posedge clk); #2 src_i[0] = 1'b1;
        @(posedge clk); #2 src_i[0] = 1'b0;
        repeat (D) @(posedge clk);
        @(negedge clk); chk("edge_latency_early", irq_o, 32'h0);
        @(negedge clk); chk("edge_latency", irq_o, 32'h1);
        rd(A_PEND, v); chk("edge_pending", v, 32'h1);
        chk("edge_irq", irq_o, 32'h1);
        rd(A_ACT, v);  chk("edge_active", v, 32'h8000_0000);
        wr(A_PEND, 32'h01, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk); chk("edge_w1c_irq", irq_o, 32'h0);

        // level source 3
        wr(A_EDGE, 32'h0, 4'hF);
        wr(A_EN, 32'h08, 4'hF);
        @(posedge clk); #2 src_i[3] = 1'b1;
        repeat (4 + D) @(posedge clk);
        @(negedge clk); chk("level_irq", irq_o, 32'h08);
        wr(A_PEND, 32'h08, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk); chk("level_w1c_ignored", irq_o, 32'h08);
        @(posedge clk); #2 src_i[3] = 1'b0;
        @(posedge clk);
        repeat (D) @(posedge clk);
        @(negedge clk); chk("level_fall_early", irq_o, 32'h08);
        @(negedge clk); chk("level_fall", irq_o, 32'h0);

        // priority between sources 2 and 5
        wr(A_EDGE, 32'h24, 4'hF);
        wr(A_EN, 32'h24, 4'hF);
        @(posedge clk); #2 src_i = 16'h0024;
        repeat (3 + D) @(posedge clk);
        rd(A_ACT, v); chk("prio_active_2", v, 32'h8000_0002);
        wr(A_PEND, 32'h04, 4'hF);
        rd(A_ACT, v); chk("prio_active_5", v, 32'h8000_0005);
        @(posedge clk); #2 src_i = '0;
        wr(A_PEND, 32'h24, 4'hF);
        rd(A_PEND, v); chk("prio_cleared", v, 32'h0);

        // W1C coinciding with a rising edge on bit 1
        wr(A_EDGE, 32'h02, 4'hF);
        wr(A_EN, 32'h02, 4'hF);
        @(posedge clk); #2 src_i[1] = 1'b1;
        repeat (D) @(posedge clk);
        wr(A_PEND, 32'h02, 4'hF);
        rd(A_PEND, v); chk("set_beats_w1c", v, 32'h02);
        chk("set_beats_w1c_irq", irq_o, 32'h02);
        @(posedge clk); #2 src_i = '0;
        wr(A_PEND, 32'h02, 4'hF);

        // byte-lane write and upper-bit masking
        wr(A_EN, 32'h0, 4'hF);
        wr(A_EN, 32'hFFFF_FFFF, 4'b0010);
        rd(A_EN, v); chk("byte_lane_enable", v, 32'h0000_FF00);
        wr(A_EN, 32'hFFFF_FFFF, 4'hF);
        rd(A_EN, v); chk("enable_upper_masked", v, 32'h0000_FFFF);
        wr(A_ACT, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #2 src_i[7] = 1'b1;
        repeat (3 + D) @(posedge clk);
        @(negedge clk); chk("pre_reset_irq", irq_o, 32'h80);

        // reset while in ACK
        @(posedge clk); #2;
        mem_valid_i = 1'b1; mem_addr_i = A_EN; mem_wstrb_i = 4'b0;
        @(posedge clk); #2;
        rst_i = 1'b1; mem_valid_i = 1'b0; src_i = '0;
        @(posedge clk); #2 rst_i = 1'b0;
        cnt = 0;
        repeat (6) begin @(negedge clk); if (mem_ready_o) cnt++; end
        chk("abandon_no_ready", 32'(cnt), 32'h0);
        chk("post_reset_irq", irq_o, 32'h0);
        rd(A_PEND, v); chk("post_reset_pending", v, 32'h0);
        rd(A_EN,   v); chk("post_reset_enable",  v, 32'h0);
        rd(A_EDGE, v); chk("post_reset_edge",    v, 32'h0);
        rd(A_ACT,  v); chk("post_reset_active",  v, 32'h0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
